// File: rtl/ffa_fir_ctrl_pkg.sv
// Shared definitions for the 2-parallel fast-FIR sequencer: state encoding,
// flush length and the coefficient tap-slice helper.
package ffa_fir_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   // Zeros needed to push every stale sample out of the sub-filters and the post-adders.
   function automatic int flush_len(input int nr_stages, input int pipe_lat);
      return pipe_lat + nr_stages / 2;
   endfunction

   // LSB position of a tap inside the flat coefficient bus.
   function automatic int tap_lsb(input int tap, input int dwidth);
      return tap * dwidth;
   endfunction

endpackage

// File: rtl/ffa_coef_bank.sv
// Shadow/active coefficient bank: taps are written one at a time into the
// shadow copy and handed to the datapath in a single commit.
module ffa_coef_bank
   import ffa_fir_ctrl_pkg::*;
#(
   parameter int NR_STAGES = 32,
   parameter int DWIDTH    = 16,
   parameter int IWIDTH    = $clog2(NR_STAGES),
   parameter int CWIDTH    = NR_STAGES * DWIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              wr_en_i,
   input  logic [IWIDTH-1:0] wr_idx_i,
   input  logic [DWIDTH-1:0] wr_data_i,
   input  logic              commit_i,
   output logic [CWIDTH-1:0] h_o
);

   logic [CWIDTH-1:0] shadow_q;
   logic [CWIDTH-1:0] shadow_d;
   logic [CWIDTH-1:0] active_q;

   // shadow_d already contains the beat being written, so a commit on the
   // last beat picks it up in the same edge.
   generate
      for (genvar gi = 0; gi < NR_STAGES; gi++) begin : g_tap
         localparam int LSB = tap_lsb(gi, DWIDTH);
         assign shadow_d[LSB +: DWIDTH] = (wr_en_i && (wr_idx_i == IWIDTH'(gi)))
                                          ? wr_data_i : shadow_q[LSB +: DWIDTH];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (clr_i)
            shadow_q <= '0;
         else
            shadow_q <= shadow_d;
         if (commit_i)
            active_q <= shadow_d;
      end
   end

   assign h_o = active_q;

endmodule

// File: rtl/ffa_fir_ctrl.sv
// Sequencer for the 2-parallel fast-FIR datapath: coefficient reload, atomic
// commit, history flush, enable-gated sample streaming and result-valid tracking.
module ffa_fir_ctrl
   import ffa_fir_ctrl_pkg::*;
#(
   parameter int NR_STAGES = 32,
   parameter int DWIDTH    = 16,
   parameter int DDWIDTH   = 2 * DWIDTH,
   parameter int CWIDTH    = NR_STAGES * DWIDTH,
   parameter int PIPE_LAT  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_start,
   input  logic               cfg_valid,
   input  logic [DWIDTH-1:0]  cfg_data,
   output logic               cfg_ready,
   input  logic               s_valid,
   input  logic [DDWIDTH-1:0] s_data,
   output logic               s_ready,
   output logic [DDWIDTH-1:0] dp_data,
   output logic               dp_en,
   output logic [CWIDTH-1:0]  h_out,
   output logic               dp_result_valid,
   output logic               coef_loaded,
   output logic               busy
);

   localparam int IWIDTH = $clog2(NR_STAGES);
   localparam int FLEN   = flush_len(NR_STAGES, PIPE_LAT);
   localparam int FCW    = $clog2(FLEN + 1);

   state_t               state_q, state_d;
   logic [IWIDTH-1:0]    idx_q;
   logic [FCW-1:0]       flush_cnt_q;
   logic [PIPE_LAT-1:0]  tok_q;
   logic                 dp_tok_q;
   logic                 dp_en_q;
   logic [DDWIDTH-1:0]   dp_data_q;
   logic                 coef_loaded_q;

   logic beat, last_beat, commit, accept;

   assign beat      = (state_q == ST_LOAD) && cfg_valid;
   assign last_beat = (idx_q == IWIDTH'(NR_STAGES - 1));
   assign commit    = beat && last_beat;
   assign accept    = (state_q == ST_RUN) && s_valid;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (cfg_start) state_d = ST_LOAD;
         ST_LOAD:  if (commit) state_d = ST_FLUSH;
         ST_FLUSH: if (flush_cnt_q == FCW'(FLEN - 1)) state_d = ST_RUN;
         ST_RUN:   if (cfg_start) state_d = ST_LOAD;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         flush_cnt_q   <= '0;
         tok_q         <= '0;
         dp_tok_q      <= 1'b0;
         dp_en_q       <= 1'b0;
         dp_data_q     <= '0;
         coef_loaded_q <= 1'b0;
      end else begin
         state_q <= state_d;

         if ((state_d == ST_LOAD) && (state_q != ST_LOAD))
            idx_q <= '0;
         else if (beat && !last_beat)
            idx_q <= idx_q + IWIDTH'(1);

         if (state_q == ST_FLUSH)
            flush_cnt_q <= flush_cnt_q + FCW'(1);
         else
            flush_cnt_q <= '0;

         // Flush cycles drive zeros with a zero token; real samples carry a one.
         dp_en_q  <= (state_d == ST_FLUSH) || accept;
         dp_tok_q <= accept;
         if (state_d == ST_FLUSH)
            dp_data_q <= '0;
         else if (accept)
            dp_data_q <= s_data;

         if (commit)
            tok_q <= '0;
         else if (dp_en_q)
            tok_q <= {tok_q[PIPE_LAT-2:0], dp_tok_q};

         if ((state_q == ST_FLUSH) && (state_d == ST_RUN))
            coef_loaded_q <= 1'b1;
      end
   end

   ffa_coef_bank #(
      .NR_STAGES (NR_STAGES),
      .DWIDTH    (DWIDTH),
      .IWIDTH    (IWIDTH),
      .CWIDTH    (CWIDTH)
   ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .clr_i     ((state_d == ST_LOAD) && (state_q != ST_LOAD)),
      .wr_en_i   (beat),
      .wr_idx_i  (idx_q),
      .wr_data_i (cfg_data),
      .commit_i  (commit),
      .h_o       (h_out)
   );

   assign cfg_ready       = (state_q == ST_LOAD);
   assign s_ready         = (state_q == ST_RUN);
   assign busy            = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
   assign dp_en           = dp_en_q;
   assign dp_data         = dp_data_q;
   assign dp_result_valid = dp_en_q && tok_q[PIPE_LAT-1];
   assign coef_loaded     = coef_loaded_q;

endmodule

// File: tb/tb_ffa_fir_ctrl.sv
// Directed bench for ffa_fir_ctrl: reset, loads with and without beat gaps,
// gapped streaming, reload mid-stream and reset mid-load.
module tb_ffa_fir_ctrl;

   localparam int NR  = 32;
   localparam int DW  = 16;
   localparam int DDW = 2 * DW;
   localparam int CW  = NR * DW;
   localparam int FL  = 20;

   logic           clk = 1'b0;
   logic           rst;
   logic           cfg_start, cfg_valid, cfg_ready;
   logic [DW-1:0]  cfg_data;
   logic           s_valid, s_ready;
   logic [DDW-1:0] s_data, dp_data;
   logic           dp_en, dp_result_valid, coef_loaded, busy;
   logic [CW-1:0]  h_out;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ffa_fir_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_start       (cfg_start),
      .cfg_valid       (cfg_valid),
      .cfg_data        (cfg_data),
      .cfg_ready       (cfg_ready),
      .s_valid         (s_valid),
      .s_data          (s_data),
      .s_ready         (s_ready),
      .dp_data         (dp_data),
      .dp_en           (dp_en),
      .h_out           (h_out),
      .dp_result_valid (dp_result_valid),
      .coef_loaded     (coef_loaded),
      .busy            (busy)
   );

   function automatic logic [DW-1:0] tap(input int i);
      return h_out[i*DW +: DW];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   logic [5:0]     pat;
   logic [DDW-1:0] last_d;

   initial begin
      rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
      s_valid = 1'b0; s_data = '0;

      // Reset
      repeat (3) tick();
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_dp_en", dp_en, 0);
      chk("rst_dp_data", dp_data, 0);
      chk("rst_rvalid", dp_result_valid, 0);
      chk("rst_coef_loaded", coef_loaded, 0);
      chk("rst_busy", busy, 0);
      chk("rst_h_zero", (h_out === '0), 1);
      rst = 1'b0;
      cfg_valid = 1'b1; cfg_data = 16'h0005;
      repeat (2) tick();
      chk("idle_cfg_ready", cfg_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_h_zero", (h_out === '0), 1);
      cfg_valid = 1'b0;
      $display("[TB] reset and idle done");

      // Back-to-back load 1..32
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      chk("load_busy", busy, 1);
      chk("load_cfg_ready", cfg_ready, 1);
      chk("load_s_ready", s_ready, 0);
      for (int i = 1; i <= NR; i++) begin
         cfg_valid = 1'b1; cfg_data = 16'(i);
         tick();
         if (i == 16) chk("load_h_held", tap(0), 0);
      end
      cfg_valid = 1'b0;
      chk("load1_tap0", tap(0), 1);
      chk("load1_tap15", tap(15), 16);
      chk("load1_tap31", tap(31), 32);
      chk("flush_coef_loaded", coef_loaded, 0);
      for (int c = 0; c < FL; c++) begin
         chk("flush_busy", busy, 1);
         chk("flush_dp_en", dp_en, 1);
         chk("flush_dp_data", dp_data, 0);
         chk("flush_rvalid", dp_result_valid, 0);
         tick();
      end
      chk("run_busy", busy, 0);
      chk("run_s_ready", s_ready, 1);
      chk("run_coef_loaded", coef_loaded, 1);
      chk("run_dp_en_idle", dp_en, 0);
      $display("[TB] load 1..32 committed, flush done");

      // Streaming with gaps: pattern 1,0,1,1,0,1 then 4 more samples
      pat = 6'b101101;
      last_d = '0;
      for (int j = 0; j < 6; j++) begin
         s_valid = pat[j]; s_data = 32'hA000_0000 + 32'(j);
         tick();
         if (pat[j]) last_d = s_data;
         chk("strm_dp_en", dp_en, pat[j]);
         chk("strm_dp_data", dp_data, last_d);
         chk("strm_rvalid_early", dp_result_valid, 0);
         $display("[TB] sample slot %0d valid=%0d", j, pat[j]);
      end
      for (int j = 0; j < 4; j++) begin
         s_valid = 1'b1; s_data = 32'hB000_0000 + 32'(j);
         tick();
         chk("strm2_dp_en", dp_en, 1);
         chk("strm2_dp_data", dp_data, 32'hB000_0000 + 32'(j));
         chk("strm2_rvalid", dp_result_valid, 1);
      end
      s_valid = 1'b0;
      tick();
      chk("strm_bubble_en", dp_en, 0);
      chk("strm_bubble_rvalid", dp_result_valid, 0);

      // Reload with cfg_valid toggling every other cycle
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      chk("gap_s_ready", s_ready, 0);
      chk("gap_busy", busy, 1);
      chk("gap_h_old", tap(0), 1);
      for (int i = 0; i < NR; i++) begin
         cfg_valid = 1'b1; cfg_data = 16'(100 + i);
         tick();
         cfg_valid = 1'b0; cfg_data = 16'hDEAD;
         if (i < NR - 1) begin
            if (i == NR - 2) begin
               chk("gap_h_held0", tap(0), 1);
               chk("gap_h_held31", tap(31), 32);
            end
            tick();
         end
      end
      chk("gap_tap0", tap(0), 100);
      chk("gap_tap17", tap(17), 117);
      chk("gap_tap31", tap(31), 131);
      chk("gap_flush_busy", busy, 1);
      repeat (FL) tick();
      chk("gap_run_s_ready", s_ready, 1);
      $display("[TB] gapped reload committed");

      // Reload mid-RUN with two tokens in flight
      s_valid = 1'b1; s_data = 32'hC000_0001; tick();
      s_data = 32'hC000_0002; tick();
      chk("mid_dp_en", dp_en, 1);
      chk("mid_dp_data", dp_data, 32'hC000_0002);
      chk("mid_rvalid", dp_result_valid, 0);
      s_valid = 1'b0; cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      chk("mid_s_ready", s_ready, 0);
      chk("mid_dp_en_load", dp_en, 0);
      chk("mid_h_old", tap(0), 100);
      for (int i = 0; i < NR; i++) begin
         cfg_valid = 1'b1; cfg_data = 16'(200 + i);
         tick();
         if (i == 20) chk("mid_h_held", tap(31), 131);
      end
      cfg_valid = 1'b0;
      chk("mid_tap0", tap(0), 200);
      chk("mid_tap31", tap(31), 231);
      for (int c = 0; c < FL; c++) begin
         chk("mid_flush_en", dp_en, 1);
         chk("mid_flush_rvalid", dp_result_valid, 0);
         tick();
      end
      chk("mid_run_s_ready", s_ready, 1);
      chk("mid_coef_loaded", coef_loaded, 1);
      $display("[TB] reload mid-run committed");

      // Reset mid-LOAD after 10 beats, then a clean load
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cfg_valid = 1'b1; cfg_data = 16'h0077;
         tick();
      end
      cfg_valid = 1'b0; rst = 1'b1;
      tick();
      chk("rstld_h_zero", (h_out === '0), 1);
      chk("rstld_coef_loaded", coef_loaded, 0);
      chk("rstld_busy", busy, 0);
      chk("rstld_cfg_ready", cfg_ready, 0);
      chk("rstld_s_ready", s_ready, 0);
      rst = 1'b0;
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      for (int i = 0; i < NR; i++) begin
         cfg_valid = 1'b1; cfg_data = 16'(1000 + i);
         tick();
      end
      cfg_valid = 1'b0;
      repeat (FL) tick();
      chk("clean_tap0", tap(0), 1000);
      chk("clean_tap9", tap(9), 1009);
      chk("clean_tap10", tap(10), 1010);
      chk("clean_tap31", tap(31), 1031);
      chk("clean_coef_loaded", coef_loaded, 1);
      chk("clean_s_ready", s_ready, 1);
      $display("[TB] reset mid-load and clean reload done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
